perf_stall_reader: RTL and testbench

Software-facing controller and reader for the encryption-stall performance counters. It decodes register writes from a simple request/response bus and turns them into the `perf_start`, `perf_en` and `perf_end` controls that drive the stall-counter block. After a measurement window closes, it captures that block's `load_enc_stall_cycle` and `store_enc_stall_cycle` results into snapshot registers. Software reads the snapshots and the window length back over the same bus, and can request an interrupt on completion.

---
 rtl/perf_stall_reader.sv | 200 ++++++++++++++++++++
 tb/tb_perf_stall_reader.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_stall_reader.sv
// perf_stall_reader
//   Software-facing controller for the encryption-stall performance counters.
//   Bus register writes become perf_start / perf_en / perf_end controls for the
//   stall-counter block. When a window closes, the block's load/store results
//   are captured into snapshot registers. Software can read the snapshots and
//   the window length, and can ask for a sticky completion interrupt.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (req_ready = ~rsp_valid)
//   req_we, req_addr,
//   req_wdata                request: 1 = write, register index, write data
//   rsp_valid/rsp_ready      response handshake (rsp_valid held until consumed)
//   rsp_rdata                read data (0 for writes and unmapped addresses)
//   perf_start               1-cycle pulse that clears the stall counters
//   perf_en                  counting enable, high only in RUN
//   perf_end                 1-cycle pulse that latches the counter results
//   load/store_enc_stall_cycle  results from the counter block
//   irq                      completion interrupt (flag & IRQ_EN)
//
// Register map: 0 CTRL, 1 LIMIT, 2 WINDOW, 3 LOAD_SNAP, 4 STORE_SNAP, 5-7 zero.
module perf_stall_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        perf_start,
  output logic        perf_en,
  output logic        perf_end,
  input  logic [31:0] load_enc_stall_cycle,
  input  logic [31:0] store_enc_stall_cycle,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_END     = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        stop_pend_reg, stop_pend_next;
  logic        perf_start_reg, perf_start_next;
  logic [31:0] limit_reg;
  logic [31:0] window_reg;
  logic [31:0] load_snap_reg;
  logic [31:0] store_snap_reg;
  logic        irq_en_reg;
  logic        irq_flag_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_rdata_reg;

  logic        accept;
  logic        wr_ctrl, wr_limit;
  logic        cmd_start, cmd_stop, cmd_irq_clr;
  logic [31:0] limit_eff;
  logic [31:0] window_inc;
  logic        limit_hit;
  logic [31:0] rd_data;

  assign accept      = req_valid & req_ready;
  assign wr_ctrl     = accept & req_we & (req_addr == 3'd0);
  assign wr_limit    = accept & req_we & (req_addr == 3'd1);
  assign cmd_start   = wr_ctrl & req_wdata[0];
  // START wins over STOP when both bits are set.
  assign cmd_stop    = wr_ctrl & req_wdata[1] & ~req_wdata[0];
  assign cmd_irq_clr = wr_ctrl & req_wdata[3];

  // A LIMIT write during RUN is compared in the same cycle it lands.
  assign limit_eff  = wr_limit ? req_wdata : limit_reg;
  // Count including the current RUN cycle, saturating at all ones.
  assign window_inc = (&window_reg) ? window_reg : window_reg + 32'd1;
  assign limit_hit  = (limit_eff != 32'd0) && (limit_eff <= window_inc);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      stop_pend_reg  <= 1'b0;
      perf_start_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      stop_pend_reg  <= stop_pend_next;
      perf_start_reg <= perf_start_next;
    end
  end

  // STOP is registered first so that the cycle after its acceptance is still
  // a counting cycle; this gives perf_end two cycles after the STOP write.
  always_comb begin
    state_next      = state_reg;
    stop_pend_next  = stop_pend_reg;
    perf_start_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        stop_pend_next = 1'b0;
        if (cmd_start) begin
          state_next      = S_RUN;
          perf_start_next = 1'b1;
        end
      end
      S_RUN: begin
        if (cmd_start) begin
          perf_start_next = 1'b1;
          stop_pend_next  = 1'b0;
        end else if (stop_pend_reg || limit_hit) begin
          // A latched STOP and a limit hit merge into a single END.
          state_next     = S_END;
          stop_pend_next = 1'b0;
        end else if (cmd_stop) begin
          stop_pend_next = 1'b1;
        end
      end
      S_END: begin
        stop_pend_next = 1'b0;
        state_next     = S_CAPTURE;
      end
      default: begin
        stop_pend_next = 1'b0;
        state_next     = S_IDLE;
      end
    endcase
  end

  // ---------------- registers and datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      limit_reg      <= '0;
      window_reg     <= '0;
      load_snap_reg  <= '0;
      store_snap_reg <= '0;
      irq_en_reg     <= 1'b0;
      irq_flag_reg   <= 1'b0;
    end else begin
      if (wr_limit) limit_reg <= req_wdata;

      if (perf_start_next)
        window_reg <= '0;
      else if (state_reg == S_RUN)
        window_reg <= window_inc;

      if (state_reg == S_CAPTURE) begin
        load_snap_reg  <= load_enc_stall_cycle;
        store_snap_reg <= store_enc_stall_cycle;
      end

      if (wr_ctrl) irq_en_reg <= req_wdata[2];

      // Clear beats a same-cycle set.
      if (cmd_irq_clr)
        irq_flag_reg <= 1'b0;
      else if ((state_reg == S_CAPTURE) && irq_en_reg)
        irq_flag_reg <= 1'b1;
    end
  end

  // Read data is taken from register values in the acceptance cycle.
  always_comb begin
    rd_data = '0;
    if (!req_we) begin
      case (req_addr)
        3'd0:    rd_data = {28'b0, irq, irq_en_reg, state_reg};
        3'd1:    rd_data = limit_reg;
        3'd2:    rd_data = window_reg;
        3'd3:    rd_data = load_snap_reg;
        3'd4:    rd_data = store_snap_reg;
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else if (accept) begin
      rsp_valid_reg <= 1'b1;
      rsp_rdata_reg <= rd_data;
    end else if (rsp_valid_reg && rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  // req_ready is masked by rst so every output reads 0 while reset is held.
  assign req_ready  = ~rsp_valid_reg & ~rst;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_rdata  = rsp_rdata_reg;
  assign perf_start = perf_start_reg;
  assign perf_en    = (state_reg == S_RUN);
  assign perf_end   = (state_reg == S_END);
  assign irq        = irq_flag_reg & irq_en_reg;

endmodule

// File: tb/tb_perf_stall_reader.sv
// Self-checking bench for perf_stall_reader. Expected response data is pushed
// to a scoreboard queue when each request is driven and popped when the
// response arrives. A negedge monitor records perf_* pulse counts and cycles.
module tb_perf_stall_reader;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        perf_start;
  logic        perf_en;
  logic        perf_end;
  logic [31:0] load_enc_stall_cycle;
  logic [31:0] store_enc_stall_cycle;
  logic        irq;

  int checks;
  int failures;
  int cyc;
  int acc_cyc;
  int start_cnt, en_cnt, end_cnt;
  int start_cyc, last_en_cyc, end_cyc;
  logic [31:0] exp_q[$];

  perf_stall_reader dut (
    .clk                   (clk),
    .rst                   (rst),
    .req_valid             (req_valid),
    .req_we                (req_we),
    .req_addr              (req_addr),
    .req_wdata             (req_wdata),
    .req_ready             (req_ready),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_rdata             (rsp_rdata),
    .perf_start            (perf_start),
    .perf_en               (perf_en),
    .perf_end              (perf_end),
    .load_enc_stall_cycle  (load_enc_stall_cycle),
    .store_enc_stall_cycle (store_enc_stall_cycle),
    .irq                   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    start_cnt = 0; en_cnt = 0; end_cnt = 0;
    start_cyc = -1; last_en_cyc = -1; end_cyc = -1;
  end
  always @(negedge clk) begin
    if (perf_start) begin start_cnt++; start_cyc = cyc; end
    if (perf_en)    begin en_cnt++;    last_en_cyc = cyc; end
    if (perf_end)   begin end_cnt++;   end_cyc = cyc; end
  end

  // ---------------- bus helpers (no checking of data here) ----------------
  task automatic bus_issue(input logic we, input logic [2:0] addr, input logic [31:0] wdata);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL bus_accept timeout addr=%0d got_ready=%b need=1", addr, req_ready);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!rsp_valid) begin
      failures++;
      $display("FAIL rsp_timeout got_valid=%b need=1", rsp_valid);
    end
    d = rsp_rdata;
    $display("txn cyc=%0d we=%b addr=%0d wdata=%h rdata=%h", acc_cyc, req_we, req_addr, req_wdata, d);
    @(posedge clk); #1;
  endtask

  task automatic xfer(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                      output logic [31:0] d);
    bus_issue(we, addr, wdata);
    get_rsp(d);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [31:0] d, e;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, perf_start, perf_en, perf_end, irq} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%b/%h/%b%b%b%b need=all0", req_ready, rsp_valid,
               rsp_rdata, perf_start, perf_en, perf_end, irq);
    end
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      exp_q.push_back(32'd0);
      xfer(1'b0, 3'(a), 32'd0, d);
      e = exp_q.pop_front(); checks++;
      if (d !== e) begin failures++; $display("FAIL reset_read a=%0d got=%h exp=%h", a, d, e); end
    end
    // unmapped write is ignored
    exp_q.push_back(32'd0);
    xfer(1'b1, 3'd5, 32'hFFFF_FFFF, d);
    exp_q.push_back(32'd0);
    xfer(1'b0, 3'd5, 32'd0, d);
    e = exp_q.pop_front(); e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", d, e); end
  endtask

  task automatic test_limited_window;
    logic [31:0] d, e;
    int t, b_en, b_end, b_st;
    logic [31:0] exp_rd [5];
    logic [2:0]  rd_addr [5];
    load_enc_stall_cycle = 32'd7; store_enc_stall_cycle = 32'd3;
    exp_q.push_back(32'd0);
    xfer(1'b1, 3'd1, 32'd10, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL limit_wr_rsp got=%h exp=%h", d, e); end
    b_en = en_cnt; b_end = end_cnt; b_st = start_cnt;
    exp_q.push_back(32'd0);
    bus_issue(1'b1, 3'd0, 32'h5);
    t = acc_cyc;
    checks++;
    if ({perf_start, perf_en} !== 2'b11) begin
      failures++; $display("FAIL start_latency got=%b%b exp=11", perf_start, perf_en);
    end
    get_rsp(d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL ctrl_wr_rsp got=%h exp=%h", d, e); end
    repeat (16) @(negedge clk);
    checks++;
    if (en_cnt - b_en !== 10) begin failures++; $display("FAIL lim_en_cycles got=%0d exp=10", en_cnt - b_en); end
    checks++;
    if (end_cnt - b_end !== 1) begin failures++; $display("FAIL lim_end_pulses got=%0d exp=1", end_cnt - b_end); end
    checks++;
    if (end_cyc !== t + 11) begin failures++; $display("FAIL lim_end_cycle got=%0d exp=%0d", end_cyc, t + 11); end
    checks++;
    if (start_cnt - b_st !== 1) begin failures++; $display("FAIL lim_start_pulses got=%0d exp=1", start_cnt - b_st); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL lim_irq got=%b exp=1", irq); end
    rd_addr = '{3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    exp_rd  = '{32'd10, 32'd7, 32'd3, 32'hC, 32'd10};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exp_rd[i]);
      xfer(1'b0, rd_addr[i], 32'd0, d);
      e = exp_q.pop_front(); checks++;
      if (d !== e) begin failures++; $display("FAIL lim_read a=%0d got=%h exp=%h", rd_addr[i], d, e); end
    end
  endtask

  task automatic test_sw_stop;
    logic [31:0] d, e;
    int s0, s1, b_end;
    exp_q.push_back(32'd0); xfer(1'b1, 3'd1, 32'd0, d); e = exp_q.pop_front();
    b_end = end_cnt;
    exp_q.push_back(32'd0); xfer(1'b1, 3'd0, 32'h1, d); e = exp_q.pop_front();
    s0 = acc_cyc;
    load_enc_stall_cycle = 32'd55; store_enc_stall_cycle = 32'd66;
    exp_q.push_back(32'd7);
    xfer(1'b0, 3'd3, 32'd0, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL stop_snap_in_run got=%h exp=%h", d, e); end
    wait_until(s0 + 20);
    bus_issue(1'b1, 3'd0, 32'h2);
    s1 = acc_cyc;
    exp_q.push_back(32'd0);
    get_rsp(d); e = exp_q.pop_front();
    // snapshot changes only after CAPTURE at s1+3
    bus_issue(1'b0, 3'd3, 32'd0);
    exp_q.push_back((acc_cyc <= s1 + 3) ? 32'd7 : 32'd55);
    get_rsp(d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL stop_snap_pre_capture got=%h exp=%h", d, e); end
    bus_issue(1'b0, 3'd4, 32'd0);
    exp_q.push_back((acc_cyc <= s1 + 3) ? 32'd3 : 32'd66);
    get_rsp(d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL stop_store_snap got=%h exp=%h", d, e); end
    exp_q.push_back(32'(s1 - s0 + 1));
    xfer(1'b0, 3'd2, 32'd0, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL stop_window got=%0d exp=%0d", d, e); end
    checks++;
    if (end_cnt - b_end !== 1) begin failures++; $display("FAIL stop_end_pulses got=%0d exp=1", end_cnt - b_end); end
    checks++;
    if (end_cyc !== s1 + 2 || last_en_cyc !== s1 + 1) begin
      failures++; $display("FAIL stop_timing got_end=%0d got_last_en=%0d exp=%0d/%0d", end_cyc, last_en_cyc, s1 + 2, s1 + 1);
    end
  endtask

  task automatic test_restart_and_simul;
    logic [31:0] d, e;
    int t0, t1, b_st, b_end;
    b_st = start_cnt;
    exp_q.push_back(32'd0); xfer(1'b1, 3'd0, 32'h1, d); e = exp_q.pop_front();
    t0 = acc_cyc;
    wait_until(t0 + 8);
    exp_q.push_back(32'd0);
    bus_issue(1'b1, 3'd0, 32'h1);
    t1 = acc_cyc;
    checks++;
    if (perf_start !== 1'b1) begin failures++; $display("FAIL restart_pulse got=%b exp=1", perf_start); end
    get_rsp(d); e = exp_q.pop_front();
    bus_issue(1'b0, 3'd2, 32'd0);
    exp_q.push_back(32'(acc_cyc - (t1 + 1)));
    get_rsp(d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL restart_window got=%0d exp=%0d", d, e); end
    checks++;
    if (start_cnt - b_st !== 2) begin failures++; $display("FAIL restart_starts got=%0d exp=2", start_cnt - b_st); end
    exp_q.push_back(32'd0); xfer(1'b1, 3'd0, 32'h2, d); e = exp_q.pop_front();
    repeat (6) @(negedge clk);
    // START|STOP in IDLE: START wins, no END
    b_end = end_cnt;
    exp_q.push_back(32'd0);
    bus_issue(1'b1, 3'd0, 32'h3);
    checks++;
    if ({perf_start, perf_en} !== 2'b11) begin failures++; $display("FAIL simul_start got=%b%b exp=11", perf_start, perf_en); end
    get_rsp(d); e = exp_q.pop_front();
    repeat (10) @(negedge clk);
    exp_q.push_back(32'h1);
    xfer(1'b0, 3'd0, 32'd0, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL simul_ctrl got=%h exp=%h", d, e); end
    checks++;
    if (end_cnt - b_end !== 0) begin failures++; $display("FAIL simul_no_end got=%0d exp=0", end_cnt - b_end); end
    exp_q.push_back(32'd0); xfer(1'b1, 3'd0, 32'h2, d); e = exp_q.pop_front();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [31:0] d, e;
    exp_q.push_back(32'd0); xfer(1'b1, 3'd1, 32'h1234, d); e = exp_q.pop_front();
    rsp_ready = 1'b0;
    exp_q.push_back(32'h1234);
    bus_issue(1'b0, 3'd1, 32'd0);
    // a pending write must wait for the held response
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd1; req_wdata = 32'hBEEF;
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold i=%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=0", i, rsp_valid, rsp_rdata, req_ready, e);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back(32'd0);
    get_rsp(d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL bp_wr_rsp got=%h exp=%h", d, e); end
    exp_q.push_back(32'hBEEF);
    xfer(1'b0, 3'd1, 32'd0, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL bp_limit got=%h exp=%h", d, e); end
  endtask

  task automatic test_irq_and_reset;
    logic [31:0] d, e;
    int b_end;
    exp_q.push_back(32'd0); xfer(1'b1, 3'd1, 32'd3, d); e = exp_q.pop_front();
    exp_q.push_back(32'd0); xfer(1'b1, 3'd0, 32'h5, d); e = exp_q.pop_front();
    repeat (10) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq); end
    exp_q.push_back(32'd0);
    bus_issue(1'b1, 3'd0, 32'hC);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_clr got=%b exp=0", irq); end
    get_rsp(d); e = exp_q.pop_front();
    exp_q.push_back(32'h4);
    xfer(1'b0, 3'd0, 32'd0, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL irq_ctrl got=%h exp=%h", d, e); end
    // reset in the middle of a window
    exp_q.push_back(32'd0); xfer(1'b1, 3'd1, 32'd100, d); e = exp_q.pop_front();
    exp_q.push_back(32'd0); xfer(1'b1, 3'd0, 32'h1, d); e = exp_q.pop_front();
    b_end = end_cnt;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({perf_start, perf_en, perf_end, irq, rsp_valid} !== 5'b0) begin
      failures++; $display("FAIL midrst_outputs got=%b%b%b%b%b exp=00000", perf_start, perf_en, perf_end, irq, rsp_valid);
    end
    rst = 1'b0;
    repeat (120) @(negedge clk);
    checks++;
    if (end_cnt - b_end !== 0) begin failures++; $display("FAIL midrst_no_end got=%0d exp=0", end_cnt - b_end); end
    for (int a = 0; a < 3; a++) begin
      exp_q.push_back(32'd0);
      xfer(1'b0, 3'(a), 32'd0, d);
      e = exp_q.pop_front(); checks++;
      if (d !== e) begin failures++; $display("FAIL midrst_read a=%0d got=%h exp=%h", a, d, e); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    load_enc_stall_cycle = '0; store_enc_stall_cycle = '0;
    test_reset();
    test_limited_window();
    test_sw_stop();
    test_restart_and_simul();
    test_backpressure();
    test_irq_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
